// File: rtl/analogizer_sync_pkg.sv
// analogizer_sync_pkg
//   Shared definitions for the Analogizer sync encoder:
//   - sync_mode encodings (SYNC_H, SYNC_HV, SYNC_SERR, SYNC_HV_ALT)
//   - line meter FSM state encoding
//   - default width of the line-period / hsync-width counters
//   - serration notch helper used by the csync mux
package analogizer_sync_pkg;

    // sync_mode encodings
    localparam logic [1:0] SYNC_H      = 2'd0;  // csync follows hsync
    localparam logic [1:0] SYNC_HV     = 2'd1;  // csync = hs | vs
    localparam logic [1:0] SYNC_SERR   = 2'd2;  // serrated csync during vsync
    localparam logic [1:0] SYNC_HV_ALT = 2'd3;  // alias of SYNC_HV

    // Default counter width: longest measurable line is 2^12-1 clocks
    localparam int unsigned DEFAULT_CNT_W = 12;

    // Line timing FSM
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMeasure = 2'd1,
        StLocked  = 2'd2
    } meter_state_e;

    // High while pos is inside one of the two serration notches of a line:
    // [0, hs_w) or [half, half + hs_w) with half = line_len / 2 (truncating).
    // Evaluated in 32 bits so half + hs_w cannot wrap.
    function automatic logic serr_notch(input int unsigned pos,
                                        input int unsigned line_len,
                                        input int unsigned hs_w);
        int unsigned half;
        half = line_len >> 1;
        return (pos < hs_w) || ((pos >= half) && (pos < half + hs_w));
    endfunction

endpackage

// File: rtl/analogizer_line_meter.sv
// analogizer_line_meter
//   Measures the video line period and hsync width and tracks whether the
//   line timing is stable.
//
//   Parameters:
//     CNT_W     width of pos / line_len / hs_w counters
//   Ports:
//     clk       video clock, all logic on posedge
//     reset     synchronous active-high reset
//     hs_now    current hsync sample (raw input)
//     hs_prev   previous hsync sample (registered copy of hs_now)
//     pos       clocks since the last hsync rise, saturating
//     line_len  last measured line period in clocks
//     hs_w      last measured hsync width in clocks
//     locked    high while the FSM is in StLocked
//
//   Edges are detected between the raw and registered hsync, so state updates
//   on the same edge that loads the registered hsync; pos reads 0 in the first
//   cycle the registered hsync is high.
module analogizer_line_meter
    import analogizer_sync_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hs_now,
    input  logic             hs_prev,
    output logic [CNT_W-1:0] pos,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] hs_w,
    output logic             locked
);

    localparam logic [CNT_W-1:0] PosMax = '1;

    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] hsw_q, hsw_d;
    logic [CNT_W-1:0] new_len;
    meter_state_e     state_q, state_d;
    logic             rise, fall, pos_sat;

    assign rise    = hs_now & ~hs_prev;
    assign fall    = ~hs_now & hs_prev;
    assign pos_sat = (pos_q == PosMax);
    // pos + 1, clamped so an over-long line never measures as 0
    assign new_len = pos_sat ? pos_q : pos_q + CNT_W'(1);

    always_comb begin
        pos_d   = pos_sat ? pos_q : pos_q + CNT_W'(1);
        len_d   = len_q;
        hsw_d   = hsw_q;
        state_d = state_q;

        if (fall) begin
            hsw_d = new_len;
        end
        if (rise) begin
            pos_d = '0;
            len_d = new_len;
        end

        // Transitions compare the fresh measurement with the previous line
        unique case (state_q)
            StIdle: begin
                if (rise) state_d = StMeasure;
            end
            StMeasure: begin
                if (rise && (new_len == len_q)) state_d = StLocked;
            end
            StLocked: begin
                if (rise && (new_len != len_q)) state_d = StMeasure;
            end
            default: state_d = StIdle;
        endcase

        // No hsync for a full counter span: timing lost from any state
        if (pos_sat) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= '0;
            len_q   <= '0;
            hsw_q   <= '0;
            state_q <= StIdle;
        end else begin
            pos_q   <= pos_d;
            len_q   <= len_d;
            hsw_q   <= hsw_d;
            state_q <= state_d;
        end
    end

    assign pos      = pos_q;
    assign line_len = len_q;
    assign hs_w     = hsw_q;
    assign locked   = (state_q == StLocked);

endmodule

// File: rtl/analogizer_sync_encoder.sv
// analogizer_sync_encoder
//   Final Analogizer video stage: blanks RGB outside active video, inverts
//   separate syncs to active-low and builds an active-low composite sync
//   (plain, hs|vs, or serrated during vsync once line timing is locked).
//
//   Parameters:
//     CNT_W        width of the line timing counters
//   Ports:
//     clk          video clock
//     reset        synchronous active-high reset
//     sync_mode    0: csync=hs, 1/3: csync=hs|vs, 2: serrated csync
//     din          {r,g,b} from the scanline stage
//     hs_in        hsync, active-high
//     vs_in        vsync, active-high
//     de_in        display enable
//     ce_in        pixel clock enable (delayed only)
//     rgb_out      blanked RGB
//     hs_n_out     hsync, active-low
//     vs_n_out     vsync, active-low
//     csync_n_out  composite sync, active-low
//     de_out       delayed de
//     ce_out       delayed ce
//     locked       line timing measured and stable
//
//   All outputs are two clocks behind the inputs: one input register stage,
//   one output register stage. sync_mode is read at the output stage so a
//   change shows up one clock later.
//
//   Build option: define ANALOGIZER_SOG_EN for sync-on-green (green byte is
//   forced to zero whenever csync_n_out is low).
module analogizer_sync_encoder
    import analogizer_sync_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  sync_mode,
    input  logic [23:0] din,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic        ce_in,
    output logic [23:0] rgb_out,
    output logic        hs_n_out,
    output logic        vs_n_out,
    output logic        csync_n_out,
    output logic        de_out,
    output logic        ce_out,
    output logic        locked
);

    // Input register stage
    logic [23:0] din_q;
    logic        hs_q, vs_q, de_q, ce_q;

    // Line meter view, aligned with the input register stage
    logic [CNT_W-1:0] pos, line_len, hs_w;
    logic             meter_locked;

    // Output stage next values
    logic [23:0] rgb_d;
    logic        csync_n_d;
    logic        csync_plain_n;
    logic        notch;

    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
            ce_q  <= 1'b0;
        end else begin
            din_q <= din;
            hs_q  <= hs_in;
            vs_q  <= vs_in;
            de_q  <= de_in;
            ce_q  <= ce_in;
        end
    end

    analogizer_line_meter #(
        .CNT_W (CNT_W)
    ) u_meter (
        .clk      (clk),
        .reset    (reset),
        .hs_now   (hs_in),
        .hs_prev  (hs_q),
        .pos      (pos),
        .line_len (line_len),
        .hs_w     (hs_w),
        .locked   (meter_locked)
    );

    assign notch = serr_notch(32'(pos), 32'(line_len), 32'(hs_w));

    always_comb begin
        csync_plain_n = ~(hs_q | vs_q);
        csync_n_d     = csync_plain_n;

        case (sync_mode)
            SYNC_H: begin
                csync_n_d = ~hs_q;
            end
            SYNC_SERR: begin
                // Serration only with trusted timing; otherwise plain hs|vs
                if (meter_locked && vs_q) begin
                    csync_n_d = notch;
                end else begin
                    csync_n_d = csync_plain_n;
                end
            end
            default: begin
                csync_n_d = csync_plain_n;
            end
        endcase

        rgb_d = de_q ? din_q : 24'h0;
`ifdef ANALOGIZER_SOG_EN
        if (!csync_n_d) begin
            rgb_d[15:8] = 8'h00;
        end
`else
        // Green follows normal blanking only
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out     <= 24'h0;
            hs_n_out    <= 1'b1;
            vs_n_out    <= 1'b1;
            csync_n_out <= 1'b1;
            de_out      <= 1'b0;
            ce_out      <= 1'b0;
            locked      <= 1'b0;
        end else begin
            rgb_out     <= rgb_d;
            hs_n_out    <= ~hs_q;
            vs_n_out    <= ~vs_q;
            csync_n_out <= csync_n_d;
            de_out      <= de_q;
            ce_out      <= ce_q;
            locked      <= meter_locked;
        end
    end

endmodule
